// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, debounces
// whole-matrix scan results and shifts each accepted key into a 16-bit number.
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] number
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [11:0]   hits_q, hits_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [15:0]   number_q, number_d;

    logic          sample, eval, accept;
    logic [3:0]    active;
    logic [15:0]   full_map;
    logic [1:0]    n_hits;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_code;
    logic          scan_none, scan_single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            hits_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            number_q    <= 16'h0000;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            number_q    <= number_d;
        end
    end

    // Rows are sampled at the end of each column dwell so the lines have settled.
    always_comb begin
        sample    = (dwell_q == DW'(SCAN_DIV - 1));
        eval      = sample && (col_idx_q == 2'd3);
        active    = ~row_sync_q;
        dwell_d   = sample ? '0 : dwell_q + 1'b1;
        col_idx_d = sample ? col_idx_q + 1'b1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        hits_d    = hits_q;
        if (sample) begin
            if (col_idx_q == 2'd3) hits_d = '0;
            else hits_d[{col_idx_q, 2'b00} +: 4] = active;
        end
    end

    // Bit c*4+r of full_map marks an active row r / column c intersection.
    always_comb begin
        full_map = {active, hits_q};
        n_hits   = 2'd0;
        hit_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_map[i]) begin
                if (n_hits != 2'd2) n_hits = n_hits + 1'b1;
                hit_idx = 4'(i);
            end
        end
        scan_none   = (n_hits == 2'd0);
        scan_single = (n_hits == 2'd1);
        hit_code    = key_lut(hit_idx[1:0], hit_idx[3:2]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (eval) begin
            case (state_q)
                IDLE: begin
                    if (scan_single) begin
                        state_d = DEBOUNCE;
                        cand_d  = hit_code;
                        cnt_d   = CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (scan_single && hit_code == cand_q) begin
                        if (cnt_q + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (scan_single) begin
                        cand_d = hit_code;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_none) begin
                        state_d = RELEASE;
                        cnt_d   = CW'(1);
                    end
                end
                default: begin
                    if (!scan_none) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // clear has priority over a coincident accept for number only.
    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? cand_q : key_code_q;
        if (clear)       number_d = 16'h0000;
        else if (accept) number_d = {number_q[11:0], cand_q};
        else             number_d = number_q;
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);
    assign number    = number_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench: a behavioural keypad drives the rows, and a scan-level
// reference model (run lengths of identical scan results) predicts every output.
module tb_hex_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] number;
    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c is down

    int tests = 0;
    int fails = 0;

    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};

    bit          m_held;
    int          m_run_len, m_none_run;
    logic [3:0]  m_run_k, m_code;
    logic [15:0] m_number;

    hex_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .clear(clear), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .number(number)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    function automatic logic [15:0] key_bit(input logic [3:0] code);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 16; i++) if (code_tab[i] == code) m = 16'(1) << i;
        return m;
    endfunction

    task automatic model_reset();
        m_held = 0; m_run_len = 0; m_none_run = 0;
        m_run_k = 4'h0; m_code = 4'h0; m_number = 16'h0000;
    endtask

    task automatic model_scan(input logic [15:0] k, input bit clr, output bit strobe);
        int n;
        logic [3:0] kc;
        strobe = 0;
        n = $countones(k);
        kc = 4'h0;
        if (n == 0) begin
            m_run_len = 0;
            if (m_held) begin
                m_none_run++;
                if (m_none_run >= DS) begin m_held = 0; m_none_run = 0; end
            end
        end else if (n == 1) begin
            for (int i = 0; i < 16; i++) if (k[i]) kc = code_tab[i];
            m_none_run = 0;
            if (m_run_len > 0 && m_run_k == kc) m_run_len++;
            else begin m_run_k = kc; m_run_len = 1; end
            if (!m_held && m_run_len == DS) begin
                strobe = 1; m_held = 1; m_code = kc;
                m_number = {m_number[11:0], kc};
            end
        end else begin
            m_run_len = 0; m_none_run = 0;
        end
        if (clr) m_number = 16'h0000;
    endtask

    // Starts at a negedge where the DUT is at the first cycle of column 0.
    task automatic do_scan(input logic [15:0] k, input bit clr, input string tag);
        bit exp_strobe;
        int strobes;
        bit col_bad;
        logic [3:0] seen_code, exp_col;
        keys = k;
        model_scan(k, clr, exp_strobe);
        strobes = 0; col_bad = 0; seen_code = 4'h0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            if (col !== exp_col) col_bad = 1;
            if (key_valid === 1'b1) begin strobes++; seen_code = key_code; end
            clear = (clr && i == 15);
        end
        tests++;
        if (strobes != int'(exp_strobe)) begin
            fails++; $display("FAIL %s.strobes got %0d want %0d", tag, strobes, exp_strobe);
        end
        if (exp_strobe) begin
            tests++;
            if (seen_code !== m_code) begin
                fails++; $display("FAIL %s.strobe_code got %h want %h", tag, seen_code, m_code);
            end
        end
        tests++;
        if (key_held !== m_held) begin
            fails++; $display("FAIL %s.key_held got %b want %b", tag, key_held, m_held);
        end
        tests++;
        if (number !== m_number) begin
            fails++; $display("FAIL %s.number got %h want %h", tag, number, m_number);
        end
        tests++;
        if (key_code !== m_code) begin
            fails++; $display("FAIL %s.key_code got %h want %h", tag, key_code, m_code);
        end
        tests++;
        if (col_bad) begin
            fails++; $display("FAIL %s.col_sequence got bad want 1110,1101,1011,0111 x4", tag);
        end
        $display("[TB] scan %s keys=%h strobes=%0d code=%h held=%b number=%h",
                 tag, k, strobes, key_code, key_held, number);
    endtask

    task automatic scans(input logic [15:0] k, input int n, input string tag);
        for (int i = 0; i < n; i++) do_scan(k, 0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || number !== 16'h0000) begin
            fails++;
            $display("FAIL %s got col=%b code=%h valid=%b held=%b num=%h want 1110/0/0/0/0000",
                     tag, col, key_code, key_valid, key_held, number);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        scans(16'h0000, 3, "idle");
    endtask

    task automatic test_single_press();
        scans(key_bit(4'h5), 6, "press5");
        scans(16'h0000, 3, "rel5");
        tests++;
        if (number !== 16'h0005) begin
            fails++; $display("FAIL press5.number got %h want 0005", number);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};
        for (int i = 0; i < 5; i++) begin
            scans(key_bit(seq[i]), 3, "seq_press");
            scans(16'h0000, 2, "seq_rel");
            if (i == 3) begin
                tests++;
                if (number !== 16'h123A) begin
                    fails++; $display("FAIL seq.number4 got %h want 123a", number);
                end
            end
        end
        tests++;
        if (number !== 16'h23AB) begin
            fails++; $display("FAIL seq.number5 got %h want 23ab", number);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            do_scan(key_bit(4'h7), 0, "bounce_on");
            do_scan(16'h0000, 0, "bounce_off");
        end
        scans(key_bit(4'h7), 3, "hold7");
        scans(16'h0000, 2, "rel7");
    endtask

    task automatic test_multi();
        scans(key_bit(4'h1) | key_bit(4'h2), 4, "multi12");
        scans(key_bit(4'h1), 3, "only1");
        scans(16'h0000, 2, "rel1");
    endtask

    task automatic test_clear_and_reset();
        do_scan(16'h0000, 1, "clr");
        scans(key_bit(4'h1), 2, "p1");
        scans(16'h0000, 2, "r1");
        scans(key_bit(4'h2), 2, "p2");
        scans(16'h0000, 2, "r2");
        tests++;
        if (number !== 16'h0012) begin
            fails++; $display("FAIL clr.pre_number got %h want 0012", number);
        end
        do_scan(key_bit(4'h9), 0, "p9a");
        do_scan(key_bit(4'h9), 1, "p9_clear");
        do_scan(key_bit(4'h9), 0, "p9_hold");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset_held");
        rst_n = 1'b1;
        scans(key_bit(4'h9), 3, "after_reset");
        scans(16'h0000, 2, "rel9");
    endtask

    task automatic test_random();
        int kind, n;
        logic [15:0] k;
        for (int step = 0; step < 30; step++) begin
            kind = $urandom_range(0, 99);
            if (kind < 60) begin
                k = 16'(1) << $urandom_range(0, 15);
                n = $urandom_range(1, 4);
            end else if (kind < 85) begin
                k = 16'h0000;
                n = $urandom_range(1, 3);
            end else begin
                k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                n = $urandom_range(1, 2);
            end
            for (int i = 0; i < n; i++) do_scan(k, ($urandom_range(0, 7) == 0), "rand");
        end
        scans(16'h0000, 2, "rand_end");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_sequence();
        test_bounce();
        test_multi();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Input-side counterpart of the 4-digit seven-segment display driver. Scans a 4x4 hex matrix keypad by driving one active-low column at a time. Synchronizes and debounces the row returns, then reports each accepted keypress as a one-cycle strobe with its hex code. Accepted digits shift into a 16-bit value (newest digit in [3:0]) that can feed the display driver's number input directly.

Parameters:
SCAN_DIV, 100000, clock cycles each column is driven (1 ms at 100 MHz); legal minimum 4.
DEBOUNCE_SCANS, 4, consecutive full scans needed to accept a press or a release; legal minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
row  input  4  keypad row returns, active low (pulled up off-chip), asynchronous to clk
clear  input  1  synchronous; zeroes number
col  output  4  keypad column drives, active low, exactly one low at a time
key_code  output  4  hex code of the most recently accepted key
key_valid  output  1  one-cycle strobe per accepted press
key_held  output  1  high while the accepted key is considered down
number  output  16  shift register of accepted digits

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All flops clear on reset, and all state is registered.
- Reset values:
  - col=4'b1110, key_code=0, key_valid=0, key_held=0, number=0.
  - FSM=IDLE, dwell, column and debounce counters all 0.
- Synchronizer: row passes through a 2-flop synchronizer before any use.
- Column scan:
  - col_idx runs 0,1,2,3,0,... and col = ~(1<<col_idx).
  - The dwell counter runs 0..SCAN_DIV-1 per column.
  - The synchronized row is sampled when dwell==SCAN_DIV-1, which gives the settle time.
  - A full scan is the 4 consecutive column samples. Its result is evaluated at the column-3 sample.
- Key map, (row r, col c) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Scan result classes:
  - NONE: no active rows in any column.
  - SINGLE(k): exactly one active row/column intersection.
  - MULTI: two or more intersections.
- FSM transitions, taken at each scan-result evaluation:
  - IDLE:
    - SINGLE(k) -> DEBOUNCE, with cand=k and cnt=1.
    - Otherwise stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED and accept the key.
    - SINGLE(j≠cand) -> stay in DEBOUNCE with cand=j and cnt=1.
    - NONE or MULTI -> IDLE with cnt=0.
  - PRESSED (key_held=1):
    - NONE -> RELEASE with cnt=1.
    - SINGLE or MULTI -> stay in PRESSED.
  - RELEASE (key_held=1):
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE and drop key_held.
    - Any key -> PRESSED with cnt=0. No new strobe is issued.
- Accept action:
  - Happens in the clock after the qualifying column-3 sample edge.
  - key_valid=1 for exactly one cycle.
  - key_code=cand, and key_code holds until the next accept.
  - number <= {number[11:0], cand}.
  - key_held rises in the same cycle as key_valid.
- Once-per-press rule: exactly one key_valid per physical press. Auto-repeat is not supported.
- clear:
  - number <= 0 on the next edge.
  - If clear coincides with an accept, clear wins: number=0, while key_valid and key_code still update.
  - FSM and scanning are unaffected by clear.
- Reset mid-operation: everything returns to reset values and scanning restarts at column 0. A key still held after reset must debounce afresh, and it produces one new strobe.

Test Plan:
1. Reset, no keys, SCAN_DIV=4, DEBOUNCE_SCANS=2 -> col sequence 1110,1101,1011,0111 with 4 cycles each and period 16. key_valid never asserts. number=0x0000.
2. Behavioural keypad model, press '5' (r1,c1) for 6 scans then release -> one key_valid strobe with key_code=5 after the 2nd full scan. number=0x0005. key_held drops 2 full scans after release.
3. Sequential presses of 1,2,3,A,B, each with a clean release -> 5 strobes; number=0x123A after the 4th press and 0x23AB after the 5th.
4. Bounce on '7' (press 1 scan, release 1 scan, repeated 4 times), then a clean hold -> no strobe during the bounce. Exactly one strobe with key_code=7 once the hold is stable for 2 scans.
5. '1' and '2' pressed together for 4 scans, then '2' released -> no strobe while MULTI. Once only '1' remains, a strobe with key_code=1 follows after 2 scans.
6. clear asserted in the same cycle as an accepted '9' with number=0x0012 -> number=0x0000, key_code=9, key_valid pulses. Then rst_n low while in PRESSED -> all outputs take reset values and col=1110. The still-held key produces one fresh strobe after 2 scans.
